// File: rtl/byteswap_pkg.sv
// Shared types and constants for the byte-swap AXI writer.
// Holds the writer FSM encoding and the bytes-per-beat helper.
package byteswap_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic int unsigned bytes_per_beat(
    input int unsigned dw
  );
    return dw / 8;
  endfunction

  localparam int unsigned DEF_DATA_WIDTH = 512;
  localparam int unsigned BYTES_PER_BEAT =
    bytes_per_beat(DEF_DATA_WIDTH);

endpackage

// File: rtl/byteswap_axi_writer.sv
// AXI4 burst writer: drains an AXIS stream of swapped words into memory.
// Ports: ctrl_* start/done/addr/size, s_axis_* input stream,
//   m_axi_aw*/w*/b* AXI4 write channels; aclk, async active-low areset_n.
module byteswap_axi_writer
  import byteswap_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_BURST_LEN        = 16
) (
  input  logic                            aclk,
  input  logic                            areset_n,
  input  logic                            ctrl_start,
  output logic                            ctrl_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  output logic                            m_axi_wlast,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  localparam int unsigned BPB =
    bytes_per_beat(C_M_AXI_DATA_WIDTH);
  localparam int LOG2_BPB = $clog2(BPB);
  localparam int XW       = C_XFER_SIZE_WIDTH;
  localparam int ADDR_W   = C_M_AXI_ADDR_WIDTH;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XW-1:0]       remain_q;
  logic [7:0]          awlen_q;
  logic [7:0]          beat_q;
  logic                awvalid_q;
  logic                bready_q;
  logic                done_q;

  logic [XW-1:0]       total_beats;
  logic [8:0]          burst_beats;
  logic [XW-1:0]       remain_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                in_w;
  logic                w_hs;

  // awlen for the next burst: min(remaining, C_BURST_LEN) - 1
  function automatic logic [7:0] len_of(
    input logic [XW-1:0] r
  );
    if (r >= XW'(C_BURST_LEN))
      return 8'(C_BURST_LEN - 1);
    return 8'(r - 1'b1);
  endfunction

  // Ceiling division by bytes-per-beat without an overflowing add
  assign total_beats =
    (ctrl_xfer_size_in_bytes >> LOG2_BPB) +
    XW'(|ctrl_xfer_size_in_bytes[LOG2_BPB-1:0]);

  assign burst_beats = {1'b0, awlen_q} + 9'd1;
  assign remain_d    = remain_q - XW'(burst_beats);
  assign addr_d      =
    addr_q + (ADDR_W'(burst_beats) << LOG2_BPB);

  assign in_w = (state_q == W);
  assign w_hs = s_axis_tvalid & m_axi_wready;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      awlen_q   <= '0;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ctrl_start) begin
            addr_q   <= ctrl_addr_offset;
            remain_q <= total_beats;
            beat_q   <= '0;
            if (total_beats == '0) begin
              state_q <= DONE;
            end else begin
              awlen_q   <= len_of(total_beats);
              awvalid_q <= 1'b1;
              state_q   <= AW;
            end
          end
        end
        AW: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= W;
          end
        end
        W: begin
          if (w_hs) begin
            if (beat_q == awlen_q) begin
              bready_q <= 1'b1;
              state_q  <= B;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        B: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            remain_q <= remain_d;
            if (remain_d == '0) begin
              state_q <= DONE;
            end else begin
              addr_q    <= addr_d;
              awlen_q   <= len_of(remain_d);
              awvalid_q <= 1'b1;
              state_q   <= AW;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl_done     = done_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_bready  = bready_q;

  // W channel is a straight combinational bridge to the stream
  assign m_axi_wvalid  = in_w & s_axis_tvalid;
  assign s_axis_tready = in_w & m_axi_wready;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wlast   = in_w & (beat_q == awlen_q);
  assign m_axi_wstrb   = '1;

endmodule
